// File: rtl/ddr4_v2_2_20_axi_ctrl_pkg.sv
// Package: ddr4_v2_2_20_axi_ctrl_pkg
// Shared definitions for the DDR4 AXI control/status channel slaves:
//   - AXI response codes
//   - write-channel FSM state encoding
//   - register-index width helper used by the address decoder and its users
package ddr4_v2_2_20_axi_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Width of a register index for n registers (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr4_v2_2_20_axi_ctrl_addr_decode.sv
// Module: ddr4_v2_2_20_axi_ctrl_addr_decode
// Combinational byte-address to register-index decoder for a bank of
// C_NUM_REG 32-bit registers placed contiguously from C_BASEADDR at a
// 4-byte stride. The two byte-offset bits of the address are ignored.
// Shared by the write- and read-channel slaves.
// Ports:
//   addr  in   C_ADDR_WIDTH  AXI byte address
//   hit   out  1             address falls inside the register window
//   idx   out  IDX_W         register index (meaningful only when hit=1)
module ddr4_v2_2_20_axi_ctrl_addr_decode
    import ddr4_v2_2_20_axi_ctrl_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASEADDR   = '0,
    parameter int                      C_NUM_REG    = 8,
    parameter int                      IDX_W        = idx_width(C_NUM_REG)
) (
    input  logic [C_ADDR_WIDTH-1:0] addr,
    output logic                    hit,
    output logic [IDX_W-1:0]        idx
);

    // One extra bit so the window limit cannot wrap when the register bank
    // sits at the very top of the address space.
    localparam logic [C_ADDR_WIDTH:0]   BASE_X   = {1'b0, C_BASEADDR};
    localparam logic [C_ADDR_WIDTH:0]   LIMIT_X  = BASE_X + (C_ADDR_WIDTH+1)'(4 * C_NUM_REG);
    localparam logic [C_ADDR_WIDTH-1:0] WORD_MSK = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [C_ADDR_WIDTH:0]   addr_x;
    logic [C_ADDR_WIDTH-1:0] offset;

    always_comb begin
        addr_x = {1'b0, addr & WORD_MSK};
        hit    = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
        offset = addr_x[C_ADDR_WIDTH-1:0] - C_BASEADDR;
        idx    = IDX_W'(offset >> 2);
    end

endmodule

// File: rtl/ddr4_v2_2_20_axi_ctrl_write.sv
// Module: ddr4_v2_2_20_axi_ctrl_write
// AXI4-Lite write-channel slave for the DDR4 AXI control/status block.
// Captures one AW and one W beat (any order), decodes the target register,
// drives a one-cycle one-hot write strobe with data into the register bank,
// then returns a B response. One transaction in flight at a time.
// Ports:
//   clk            in   1               clock
//   reset_n        in   1               asynchronous active-low reset
//   s_axi_awaddr   in   C_ADDR_WIDTH    write address
//   s_axi_awvalid  in   1               AW valid
//   s_axi_awready  out  1               AW ready (registered)
//   s_axi_wdata    in   C_DATA_WIDTH    write data
//   s_axi_wstrb    in   C_DATA_WIDTH/8  byte strobes (all must be set)
//   s_axi_wvalid   in   1               W valid
//   s_axi_wready   out  1               W ready (registered)
//   s_axi_bresp    out  2               OKAY or SLVERR, stable while bvalid
//   s_axi_bvalid   out  1               B valid
//   s_axi_bready   in   1               B ready
//   reg_we         out  C_NUM_REG       one-hot write strobe, one cycle
//   reg_data       out  C_DATA_WIDTH    data for the strobed register
module ddr4_v2_2_20_axi_ctrl_write
    import ddr4_v2_2_20_axi_ctrl_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH  = 32,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASEADDR    = '0,
    parameter int                      C_NUM_REG     = 8,
    parameter logic [C_NUM_REG-1:0]    C_REG_WR_MASK = {C_NUM_REG{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [C_NUM_REG-1:0]      reg_we,
    output logic [C_DATA_WIDTH-1:0]   reg_data
);

    localparam int IDX_W = idx_width(C_NUM_REG);

    state_e state_q, state_d;

    logic                      aw_done_q, w_done_q;
    logic [C_ADDR_WIDTH-1:0]   awaddr_q;
    logic [C_DATA_WIDTH-1:0]   wdata_q;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q;
    logic                      wr_ok_q;

    logic                      aw_hs, w_hs, both_captured;
    logic [C_ADDR_WIDTH-1:0]   addr_eff;
    logic [C_DATA_WIDTH-1:0]   wdata_eff;
    logic [C_DATA_WIDTH/8-1:0] wstrb_eff;
    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic [C_NUM_REG-1:0]      sel_onehot;
    logic                      wr_legal;

    // Handshakes and the beat contents as seen at the edge that completes the
    // pair: a channel captured earlier comes from its holding register, the
    // one handshaking now comes straight from the bus. This lets the strobe
    // be registered on the same edge as the last handshake.
    always_comb begin
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        both_captured = (aw_done_q || aw_hs) && (w_done_q || w_hs);
        addr_eff      = aw_done_q ? awaddr_q : s_axi_awaddr;
        wdata_eff     = w_done_q  ? wdata_q  : s_axi_wdata;
        wstrb_eff     = w_done_q  ? wstrb_q  : s_axi_wstrb;
    end

    ddr4_v2_2_20_axi_ctrl_addr_decode #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_BASEADDR   (C_BASEADDR),
        .C_NUM_REG    (C_NUM_REG),
        .IDX_W        (IDX_W)
    ) u_addr_decode (
        .addr (addr_eff),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // NOTE: every variable assigned in an always_comb gets a default before any
    // conditional assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < C_NUM_REG; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                sel_onehot[i] = dec_hit;
            end
        end
        // Miss, read-only register, or partial byte strobe all reject the write.
        wr_legal = (|(sel_onehot & C_REG_WR_MASK)) && (&wstrb_eff);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (both_captured) state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (s_axi_bvalid && s_axi_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wr_ok_q       <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            reg_we        <= '0;
            reg_data      <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                        awaddr_q  <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                    end
                    if (both_captured) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        wr_ok_q       <= wr_legal;
                        reg_we        <= wr_legal ? sel_onehot : '0;
                        if (wr_legal) begin
                            reg_data <= wdata_eff;
                        end
                    end else begin
                        s_axi_awready <= !(aw_done_q || aw_hs);
                        s_axi_wready  <= !(w_done_q || w_hs);
                    end
                end
                WRITE: begin
                    reg_we       <= '0;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= wr_ok_q ? RESP_OKAY : RESP_SLVERR;
                end
                RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_done_q     <= 1'b0;
                        w_done_q      <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                default: begin
                    reg_we       <= '0;
                    s_axi_bvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_ctrl_write.sv
// Testbench: tb_ddr4_v2_2_20_axi_ctrl_write
// Two instances share one AXI master: u_dut_rw has every register writable,
// u_dut_ro has register 0 read-only. Both sit at base 0x1000 with 8 registers.
module tb_ddr4_v2_2_20_axi_ctrl_write;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_bready;

    logic        awready0, wready0, bvalid0;
    logic [1:0]  bresp0;
    logic [7:0]  reg_we0;
    logic [31:0] reg_data0;
    logic        awready1, wready1, bvalid1;
    logic [1:0]  bresp1;
    logic [7:0]  reg_we1;
    logic [31:0] reg_data1;

    int checks = 0;
    int errors = 0;
    int pulses0 = 0;
    int multihot = 0;
    logic [7:0]  last_we0;
    logic [31:0] last_data0;

    logic [7:0]  cap_we0, cap_we1;
    logic [31:0] cap_data0;
    logic        cap_bv0;
    logic [1:0]  cap_resp0, cap_resp1;

    always #5 clk = ~clk;

    ddr4_v2_2_20_axi_ctrl_write #(
        .C_BASEADDR    (BASE),
        .C_NUM_REG     (8),
        .C_REG_WR_MASK (8'hFF)
    ) u_dut_rw (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (awready0),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (wready0),
        .s_axi_bresp   (bresp0),
        .s_axi_bvalid  (bvalid0),
        .s_axi_bready  (s_axi_bready),
        .reg_we        (reg_we0),
        .reg_data      (reg_data0)
    );

    ddr4_v2_2_20_axi_ctrl_write #(
        .C_BASEADDR    (BASE),
        .C_NUM_REG     (8),
        .C_REG_WR_MASK (8'hFE)
    ) u_dut_ro (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (awready1),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (wready1),
        .s_axi_bresp   (bresp1),
        .s_axi_bvalid  (bvalid1),
        .s_axi_bready  (s_axi_bready),
        .reg_we        (reg_we1),
        .reg_data      (reg_data1)
    );

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (reg_we0 != 8'h00) begin
                pulses0++;
                last_we0   = reg_we0;
                last_data0 = reg_data0;
            end
            if ($countones(reg_we0) > 1 || $countones(reg_we1) > 1) multihot++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented together with bready high. Captures the strobe cycle
    // (N+1) and the response cycle (N+2), returns in the idle cycle N+3.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        step();
        cap_we0       = reg_we0;
        cap_we1       = reg_we1;
        cap_data0     = reg_data0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        step();
        cap_bv0   = bvalid0;
        cap_resp0 = bresp0;
        cap_resp1 = bresp1;
        step();
    endtask

    initial begin
        int p;
        reset_n       = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        step();
        step();
        check("rst_awready", awready0, 0);
        check("rst_wready",  wready0,  0);
        check("rst_bvalid",  bvalid0,  0);
        check("rst_bresp",   bresp0,   0);
        check("rst_reg_we",  reg_we0,  0);
        check("rst_reg_data", reg_data0, 0);
        reset_n = 1'b1;
        step();
        check("idle_awready", awready0, 1);
        check("idle_wready",  wready0,  1);

        // 1: AW+W same cycle to register 2
        s_axi_awaddr  = BASE + 32'd8;
        s_axi_wdata   = 32'hDEAD_BEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        step();
        check("t1_we",       reg_we0,   32'h04);
        check("t1_data",     reg_data0, 32'hDEAD_BEEF);
        check("t1_awr_low",  awready0,  0);
        check("t1_wr_low",   wready0,   0);
        check("t1_bv_early", bvalid0,   0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        step();
        check("t1_we_off",  reg_we0, 0);
        check("t1_bvalid",  bvalid0, 1);
        check("t1_bresp",   bresp0,  2'b00);
        step();
        check("t1_bv_done", bvalid0,  0);
        check("t1_awr_back", awready0, 1);
        check("t1_wr_back",  wready0,  1);

        // 2: W two cycles before AW to register 0, bready held low 3 cycles
        p = pulses0;
        s_axi_bready = 1'b0;
        s_axi_wdata  = 32'h1234_5678;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        check("t2_wr_drop",  wready0,  0);
        check("t2_awr_hold", awready0, 1);
        step();
        check("t2_wr_stay", wready0, 0);
        s_axi_awaddr  = BASE;
        s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        check("t2_we",   reg_we0,   32'h01);
        check("t2_data", reg_data0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_bv_hold",   bvalid0, 1);
            check("t2_bresp_hold", bresp0, 2'b00);
            check("t2_awr_resp",  awready0, 0);
        end
        s_axi_bready = 1'b1;
        step();
        check("t2_bv_done", bvalid0, 0);
        check("t2_pulses",  pulses0 - p, 1);
        step();

        // 3: first out-of-range word and the word below the base
        issue(BASE + 32'd32, 32'hAAAA_5555, 4'hF);
        check("t3_hi_we",    cap_we0,   0);
        check("t3_hi_bv",    cap_bv0,   1);
        check("t3_hi_bresp", cap_resp0, 2'b10);
        issue(BASE - 32'd4, 32'hAAAA_5555, 4'hF);
        check("t3_lo_we",    cap_we0,   0);
        check("t3_lo_bresp", cap_resp0, 2'b10);
        // last in-range word, byte-offset bits ignored
        issue(BASE + 32'd31, 32'h0BAD_F00D, 4'hF);
        check("t3_top_we",    cap_we0,   32'h80);
        check("t3_top_bresp", cap_resp0, 2'b00);

        // 4: read-only register 0 on the masked instance, partial strobe
        issue(BASE, 32'h5A5A_5A5A, 4'hF);
        check("t4_ro_we1",    cap_we1,   0);
        check("t4_ro_bresp1", cap_resp1, 2'b10);
        check("t4_rw_we0",    cap_we0,   32'h01);
        check("t4_rw_bresp0", cap_resp0, 2'b00);
        issue(BASE + 32'd4, 32'h1111_2222, 4'b0111);
        check("t4_strb_we0",    cap_we0,   0);
        check("t4_strb_we1",    cap_we1,   0);
        check("t4_strb_bresp0", cap_resp0, 2'b10);
        check("t4_strb_bresp1", cap_resp1, 2'b10);

        // 5: reset during RESP
        s_axi_bready  = 1'b0;
        s_axi_awaddr  = BASE + 32'd12;
        s_axi_wdata   = 32'hCAFE_0003;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        step();
        check("t5_bv_pre", bvalid0, 1);
        reset_n = 1'b0;
        #1;
        check("t5_bv_async", bvalid0, 0);
        check("t5_awr_rst",  awready0, 0);
        step();
        reset_n = 1'b1;
        check("t5_awr_still", awready0, 0);
        step();
        check("t5_awr_back", awready0, 1);
        check("t5_wr_back",  wready0,  1);
        check("t5_bv_none",  bvalid0,  0);

        // back-to-back writes: one strobe per B handshake
        p = pulses0;
        issue(BASE + 32'd12, 32'h0000_0033, 4'hF);
        check("bb_we3", cap_we0, 32'h08);
        issue(BASE + 32'd20, 32'h0000_0055, 4'hF);
        check("bb_we5", cap_we0, 32'h20);
        check("bb_d5",  cap_data0, 32'h0000_0055);
        issue(BASE + 32'd28, 32'h0000_0077, 4'hF);
        check("bb_we7",     cap_we0,    32'h80);
        check("bb_pulses",  pulses0 - p, 3);
        check("bb_last_we", last_we0,   32'h80);
        check("bb_last_d",  last_data0, 32'h0000_0077);
        check("multihot",   multihot,   0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
